// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - turns one command into the LOAD/EXEC/OUT/CAPT opcode sequence for the shared ALU.
// Optional status counters are enabled with ALU_SEQ_STATUS_CNT_EN.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  a_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_operand,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_error,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data_in,
  input  logic [DATA_WIDTH-1:0] alu_data_out,
  input  logic                  alu_acc_zero,
  input  logic                  alu_acc_overflow,
  output logic [CNT_WIDTH-1:0]  cmd_count,
  output logic [CNT_WIDTH-1:0]  ovf_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT, S_CAPT, S_RESP} state_t;

  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_NOOP = 4'hF;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic                  rsp_overflow_q, rsp_overflow_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [3:0]            alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH-1:0] alu_data_in_q, alu_data_in_d;

  // Every output is a flop, so the opcode for a state is computed on the edge entering it.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_error_d    = rsp_error_q;
    alu_opcode_d   = OP_NOOP;
    alu_data_in_d  = alu_data_in_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          cmd_ready_d = 1'b0;
          if (cmd_op[3]) begin
            state_d        = S_RESP;
            rsp_valid_d    = 1'b1;
            rsp_error_d    = 1'b1;
            rsp_data_d     = '0;
            rsp_zero_d     = 1'b0;
            rsp_overflow_d = 1'b0;
          end else if (cmd_op >= 4'd1 && cmd_op <= 4'd5) begin
            state_d       = S_LOAD;
            alu_opcode_d  = OP_LOAD;
            alu_data_in_d = cmd_operand;
          end else begin
            state_d      = S_EXEC;
            alu_opcode_d = cmd_op;
          end
        end
      end
      S_LOAD: begin
        state_d      = S_EXEC;
        alu_opcode_d = op_q;
      end
      S_EXEC: begin
        state_d      = S_OUT;
        alu_opcode_d = OP_OUT;
      end
      S_OUT: begin
        // Flags are live off the accumulator, which settled at the EXEC edge.
        state_d        = S_CAPT;
        rsp_zero_d     = alu_acc_zero;
        rsp_overflow_d = alu_acc_overflow;
      end
      S_CAPT: begin
        state_d     = S_RESP;
        rsp_data_d  = alu_data_out;
        rsp_error_d = 1'b0;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      alu_opcode_q   <= OP_NOOP;
      alu_data_in_q  <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_error_q    <= rsp_error_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_data_in_q  <= alu_data_in_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_error    = rsp_error_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_data_in  = alu_data_in_q;

`ifdef ALU_SEQ_STATUS_CNT_EN
  logic [CNT_WIDTH-1:0] cmd_count_q, cmd_count_d;
  logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;

  always_comb begin
    cmd_count_d = cmd_count_q;
    ovf_count_d = ovf_count_q;
    if (state_q == S_RESP && rsp_ready) begin
      cmd_count_d = cmd_count_q + 1'b1;
      if (rsp_overflow_q) ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      cmd_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      cmd_count_q <= cmd_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign cmd_count = cmd_count_q;
  assign ovf_count = ovf_count_q;
`else
  assign cmd_count = '0;
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a behavioural accumulator ALU attached.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        a_reset = 1'b1;
  logic        alu_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_operand = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        rsp_zero, rsp_overflow, rsp_error;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_data_in;
  logic [7:0]  alu_data_out;
  logic        alu_acc_zero, alu_acc_overflow;
  logic [15:0] cmd_count, ovf_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .a_reset(a_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .alu_opcode(alu_opcode), .alu_data_in(alu_data_in), .alu_data_out(alu_data_out),
    .alu_acc_zero(alu_acc_zero), .alu_acc_overflow(alu_acc_overflow),
    .cmd_count(cmd_count), .ovf_count(ovf_count)
  );

  // Accumulator ALU: 9-bit acc, register A, registered data_out; has its own reset.
  logic [8:0] acc;
  logic [7:0] reg_a;
  logic [7:0] dout;
  always @(posedge clk or posedge alu_rst) begin
    if (alu_rst) begin
      acc <= '0; reg_a <= '0; dout <= '0;
    end else begin
      case (alu_opcode)
        4'h0: acc <= '0;
        4'h1: acc <= {1'b0, acc[7:0]} + {1'b0, reg_a};
        4'h2: acc <= {1'b0, acc[7:0]} - {1'b0, reg_a};
        4'h3: acc <= {1'b0, acc[7:0] & reg_a};
        4'h4: acc <= {1'b0, acc[7:0] | reg_a};
        4'h5: acc <= {1'b0, acc[7:0] ^ reg_a};
        4'h6: acc <= {acc[7:0], 1'b0};
        4'h7: acc <= {2'b00, acc[7:1]};
        4'h8: reg_a <= alu_data_in;
        4'h9: dout <= acc[7:0];
        default: ;
      endcase
    end
  end
  assign alu_data_out     = dout;
  assign alu_acc_zero     = (acc == 9'd0);
  assign alu_acc_overflow = acc[8];

  task automatic test_reset();
    a_reset = 1'b1; alu_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_rsp: got rdy=%b v=%b d=%h z=%b o=%b e=%b want rdy=1 v=0 d=00 z=0 o=0 e=0",
               cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error);
    end
    n_tests++;
    if ({alu_opcode, alu_data_in, cmd_count, ovf_count} !== {4'hF, 8'h00, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_alu: got op=%h din=%h cc=%0d oc=%0d want op=f din=00 cc=0 oc=0",
               alu_opcode, alu_data_in, cmd_count, ovf_count);
    end
    a_reset = 1'b0; alu_rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || alu_opcode !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b op=%h want rdy=1 op=f", cmd_ready, alu_opcode);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the sequencer in IDLE and rsp_ready=1.
  task automatic do_cmd(input string name, input logic [3:0] op, input logic [7:0] operand,
                        input int exp_lat, input logic [15:0] exp_seq, input logic [7:0] exp_data,
                        input logic exp_zero, input logic exp_ovf, input logic exp_err);
    int n;
    logic [15:0] seq;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = operand;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 8'h00;
    n = 0; seq = '0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      seq = {seq[11:0], alu_opcode};
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n + 1 != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got T+%0d want T+%0d", name, n + 1, exp_lat);
    end
    n_tests++;
    if (seq !== exp_seq) begin
      n_fail++;
      $display("FAIL %s_opseq: got %h want %h", name, seq, exp_seq);
    end
    n_tests++;
    if ({rsp_data, rsp_zero, rsp_overflow, rsp_error, alu_opcode} !== {exp_data, exp_zero, exp_ovf, exp_err, 4'hF}) begin
      n_fail++;
      $display("FAIL %s_rsp: got d=%h z=%b o=%b e=%b op=%h want d=%h z=%b o=%b e=%b op=f",
               name, rsp_data, rsp_zero, rsp_overflow, rsp_error, alu_opcode,
               exp_data, exp_zero, exp_ovf, exp_err);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: got v=%b rdy=%b want v=0 rdy=1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_cmd("add05",  4'h1, 8'h05, 5, 16'h819F, 8'h05, 1'b0, 1'b0, 1'b0);
    do_cmd("addff",  4'h1, 8'hFF, 5, 16'h819F, 8'h04, 1'b0, 1'b1, 1'b0);
    do_cmd("lshift", 4'h6, 8'hAA, 4, 16'h069F, 8'h08, 1'b0, 1'b0, 1'b0);
    do_cmd("clear",  4'h0, 8'h33, 4, 16'h009F, 8'h00, 1'b1, 1'b0, 1'b0);
    do_cmd("sub01",  4'h2, 8'h01, 5, 16'h829F, 8'hFF, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_counters();
`ifdef ALU_SEQ_STATUS_CNT_EN
    n_tests++;
    if (cmd_count !== 16'd5 || ovf_count !== 16'd2) begin
      n_fail++;
      $display("FAIL counters: got cc=%0d oc=%0d want cc=5 oc=2", cmd_count, ovf_count);
    end
`else
    n_tests++;
    if (cmd_count !== 16'd0 || ovf_count !== 16'd0) begin
      n_fail++;
      $display("FAIL counters_tied: got cc=%0d oc=%0d want cc=0 oc=0", cmd_count, ovf_count);
    end
`endif
  endtask

  task automatic test_illegal();
    do_cmd("illegal", 4'hA, 8'h77, 1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_rsp_stall();
    int n;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'h5; cmd_operand = 8'h0F;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n != 4 || rsp_data !== 8'hF0 || rsp_zero !== 1'b0 || rsp_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rsp: got lat=T+%0d d=%h z=%b o=%b want lat=T+5 d=f0 z=0 o=0",
               n + 1, rsp_data, rsp_zero, rsp_overflow);
    end
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_operand = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error, cmd_ready, alu_opcode} !==
          {1'b1, 8'hF0, 3'b000, 1'b0, 4'hF}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h z=%b o=%b e=%b rdy=%b op=%h want v=1 d=f0 z=0 o=0 e=0 rdy=0 op=f",
                 i, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error, cmd_ready, alu_opcode);
      end
    end
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 8'h00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (alu_opcode !== 4'hF || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_accept: got op=%h rdy=%b want op=f rdy=1", alu_opcode, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_operand = 8'h10;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 8'h00;
    n = 0;
    while (alu_opcode !== 4'h1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL midreset_exec_reach: got EXEC at cycle %0d want 1", n);
    end
    a_reset = 1'b1;
    #1;
    n_tests++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error, alu_opcode, alu_data_in, cmd_count, ovf_count} !==
        {1'b1, 1'b0, 8'h00, 3'b000, 4'hF, 8'h00, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b d=%h z=%b o=%b e=%b op=%h din=%h cc=%0d oc=%0d want reset values",
               cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_overflow, rsp_error, alu_opcode, alu_data_in,
               cmd_count, ovf_count);
    end
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0;
    @(posedge clk); #1;
    do_cmd("after_reset", 4'h3, 8'h3C, 5, 16'h839F, 8'h30, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_STATUS_CNT_EN
    n_tests++;
    if (cmd_count !== 16'd1 || ovf_count !== 16'd0) begin
      n_fail++;
      $display("FAIL counters_after_reset: got cc=%0d oc=%0d want cc=1 oc=0", cmd_count, ovf_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_counters();
    test_illegal();
    test_rsp_stall();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
